// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage: mem_op bit positions, FSM encodings, default widths.
package wb_pkg;

    // One-hot mem_op bit positions
    localparam int unsigned MOP_LB   = 0;
    localparam int unsigned MOP_LH   = 1;
    localparam int unsigned MOP_LW   = 2;
    localparam int unsigned MOP_LBU  = 3;
    localparam int unsigned MOP_LHU  = 4;
    localparam int unsigned MOP_LWU  = 5;
    localparam int unsigned MOP_LD   = 6;
    localparam int unsigned MOP_RSVD = 7;

    // FSM state encodings
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Default widths
    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned RADDR_W_DEF = 5;
    localparam int unsigned ECODE_W_DEF = 6;
    localparam int unsigned ESUB_W_DEF  = 9;

endpackage

// File: rtl/wb_load_align.sv
// Load data alignment: picks the addressed lane of the response and sign/zero-extends it.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OffW = 2
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [OffW-1:0] off_i,
    input  logic [7:0]      mem_op_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] word_s;
    logic            half_ok;
    logic            word_ok;

    // Shift the addressed byte down to lane 0; misaligned accesses yield 0
    always_comb begin
        sh      = rdata_i >> {off_i, 3'b000};
        half_ok = (off_i[0] == 1'b0);
        word_ok = (off_i[1:0] == 2'b00);
        word_s  = word_ok ? XLEN'($signed(sh[31:0])) : '0;
    end

    // Extend the selected lane according to the one-hot load type
    always_comb begin
        data_o = '0;
        unique case (1'b1)
            mem_op_i[MOP_LB]:   data_o = XLEN'($signed(sh[7:0]));
            mem_op_i[MOP_LBU]:  data_o = XLEN'(sh[7:0]);
            mem_op_i[MOP_LH]:   data_o = half_ok ? XLEN'($signed(sh[15:0])) : '0;
            mem_op_i[MOP_LHU]:  data_o = half_ok ? XLEN'(sh[15:0]) : '0;
            mem_op_i[MOP_LW]:   data_o = word_s;
            mem_op_i[MOP_LWU]: begin
                if (XLEN == 64) data_o = word_ok ? XLEN'(sh[31:0]) : '0;
                else            data_o = word_s;
            end
            mem_op_i[MOP_LD]: begin
                // 32-bit datapath has no doubleword: LD degrades to LW
                if (XLEN == 64) data_o = (off_i == '0) ? sh : '0;
                else            data_o = word_s;
            end
            mem_op_i[MOP_RSVD]: data_o = '0;
            default:            data_o = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage_gen.sv
// Writeback stage: registers one instruction from MEM, waits for load data, then retires it
// to the regfile or submits its exception/ertn to the CSR unit.
module wb_stage_gen
    import wb_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned RADDR_W = RADDR_W_DEF,
    parameter int unsigned ECODE_W = ECODE_W_DEF,
    parameter int unsigned ESUB_W  = ESUB_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [XLEN-1:0]    in_pc_i,
    input  logic [XLEN-1:0]    in_result_i,
    input  logic [7:0]         in_mem_op_i,
    input  logic               in_res_from_mem_i,
    input  logic               in_gr_we_i,
    input  logic [RADDR_W-1:0] in_dest_i,
    input  logic               in_has_exc_i,
    input  logic [ECODE_W-1:0] in_ecode_i,
    input  logic [ESUB_W-1:0]  in_esubcode_i,
    input  logic [XLEN-1:0]    in_maddr_i,
    input  logic               in_ertn_i,
    input  logic               data_ok_i,
    input  logic [XLEN-1:0]    data_rdata_i,
    output logic               rf_we_o,
    output logic [RADDR_W-1:0] rf_waddr_o,
    output logic [XLEN-1:0]    rf_wdata_o,
    output logic               fwd_valid_o,
    output logic               fwd_busy_o,
    output logic [RADDR_W-1:0] fwd_dest_o,
    output logic [XLEN-1:0]    fwd_data_o,
    output logic               exc_submit_o,
    output logic [ECODE_W-1:0] exc_ecode_o,
    output logic [ESUB_W-1:0]  exc_esubcode_o,
    output logic [XLEN-1:0]    exc_pc_o,
    output logic [XLEN-1:0]    exc_maddr_o,
    output logic               ertn_submit_o,
    output logic               flush_o,
    output logic [XLEN-1:0]    debug_wb_pc_o,
    output logic [3:0]         debug_wb_rf_we_o,
    output logic [RADDR_W-1:0] debug_wb_rf_wnum_o,
    output logic [XLEN-1:0]    debug_wb_rf_wdata_o
);

    localparam int unsigned OffW = (XLEN == 64) ? 3 : 2;

    logic [1:0]         state_q, state_d;
    logic [XLEN-1:0]    rdata_q, rdata_d;
    logic [XLEN-1:0]    pc_q, result_q, maddr_q;
    logic [7:0]         mem_op_q;
    logic               from_mem_q, gr_we_q, has_exc_q, ertn_q;
    logic [RADDR_W-1:0] dest_q;
    logic [ECODE_W-1:0] ecode_q;
    logic [ESUB_W-1:0]  esub_q;

    logic            st_wait, st_done, ready, flush, capture, load_wait;
    logic [XLEN-1:0] load_val, final_val;

    assign st_wait   = (state_q == ST_WAIT);
    assign st_done   = (state_q == ST_DONE);
    assign ready     = (state_q == ST_EMPTY) | st_done;
    assign flush     = st_done & (has_exc_q | ertn_q);
    assign capture   = in_valid_i & ready & ~flush;
    // A load carrying an exception never issued a request, so it must not wait
    assign load_wait = in_res_from_mem_i & ~in_has_exc_i;

    // Next state and load-data latch
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        if (capture) begin
            state_d = (load_wait & ~data_ok_i) ? ST_WAIT : ST_DONE;
            if (load_wait & data_ok_i) rdata_d = data_rdata_i;
        end else begin
            unique case (state_q)
                ST_WAIT: begin
                    if (data_ok_i) begin
                        state_d = ST_DONE;
                        rdata_d = data_rdata_i;
                    end
                end
                ST_DONE: state_d = ST_EMPTY;
                default: state_d = state_q;
            endcase
        end
    end

    // State, load data and instruction payload registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_EMPTY;
            rdata_q    <= '0;
            pc_q       <= '0;
            result_q   <= '0;
            maddr_q    <= '0;
            mem_op_q   <= '0;
            from_mem_q <= 1'b0;
            gr_we_q    <= 1'b0;
            has_exc_q  <= 1'b0;
            ertn_q     <= 1'b0;
            dest_q     <= '0;
            ecode_q    <= '0;
            esub_q     <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            if (capture) begin
                pc_q       <= in_pc_i;
                result_q   <= in_result_i;
                maddr_q    <= in_maddr_i;
                mem_op_q   <= in_mem_op_i;
                from_mem_q <= in_res_from_mem_i;
                gr_we_q    <= in_gr_we_i;
                has_exc_q  <= in_has_exc_i;
                ertn_q     <= in_ertn_i;
                dest_q     <= in_dest_i;
                ecode_q    <= in_ecode_i;
                esub_q     <= in_esubcode_i;
            end
        end
    end

    wb_load_align #(
        .XLEN (XLEN),
        .OffW (OffW)
    ) u_align (
        .rdata_i  (rdata_q),
        .off_i    (result_q[OffW-1:0]),
        .mem_op_i (mem_op_q),
        .data_o   (load_val)
    );

    // Retire, exception/ertn submission and forwarding outputs
    always_comb begin
        final_val           = from_mem_q ? load_val : result_q;
        // Held low during reset so no output reports readiness
        in_ready_o          = rst_ni & ready;
        rf_we_o             = st_done & gr_we_q & ~has_exc_q;
        rf_waddr_o          = dest_q;
        rf_wdata_o          = final_val;
        fwd_valid_o         = (st_wait | st_done) & gr_we_q & ~has_exc_q;
        fwd_busy_o          = st_wait;
        fwd_dest_o          = dest_q;
        fwd_data_o          = final_val;
        exc_submit_o        = st_done & has_exc_q;
        exc_ecode_o         = ecode_q;
        exc_esubcode_o      = esub_q;
        exc_pc_o            = pc_q;
        exc_maddr_o         = maddr_q;
        ertn_submit_o       = st_done & ertn_q & ~has_exc_q;
        flush_o             = flush;
        debug_wb_pc_o       = pc_q;
        debug_wb_rf_we_o    = {4{rf_we_o}};
        debug_wb_rf_wnum_o  = dest_q;
        debug_wb_rf_wdata_o = final_val;
    end

endmodule
